irq_priority_ctrl: RTL and testbench
====================================

Name: irq_priority_ctrl

Overview:
- Nested, prioritised interrupt controller that sequences the CPU's exception path in the WB stage.
- Synchronises and latches up to N_IRQ asynchronous break sources and arbitrates them by fixed priority against the in-service level.
- Drives a one-cycle take pulse with a vector address to the PC unit, and keeps an EPC/level stack so that eret resumes the preempted context.
- Exposes mask, status and pending state through a CP0-style mfc0/mtc0 register port.

Parameters:
- N_IRQ, 3: number of interrupt sources. Source i has priority level i+1; level 0 is the normal program.
- VEC_BASE, 32'h0000_0C00: handler address for source 0.
- VEC_STRIDE, 32'h0000_0040: address step between handlers. Vector for source i = VEC_BASE + i*VEC_STRIDE.

Ports:
- clk  in  1  system clock (rising edge)
- rst  in  1  reset, asynchronous, active-high
- irq_in  in  N_IRQ  raw asynchronous interrupt requests; a rising edge requests service
- pc_next  in  32  address of the instruction after the one in WB; pushed as EPC
- eret  in  1  decoded eret in WB, one cycle
- cp0_we  in  1  mtc0 write strobe
- cp0_addr  in  5  CP0 register select
- cp0_wdata  in  32  mtc0 data
- cp0_rdata  out  32  mfc0 data, combinational from cp0_addr
- take  out  1  one-cycle pulse; PC unit loads vector at the end of this cycle
- vector  out  32  handler address, valid while take=1
- epc_out  out  32  top-of-stack EPC; PC unit uses it on eret
- level  out  2  current in-service level (0..N_IRQ)
- pending  out  N_IRQ  latched requests

Behaviour:
- Reset: all outputs, pending, stack, depth and level are 0; FSM in RUN; IE=1; mask all ones (all sources enabled); ERR=0.
- Input capture: each irq_in passes a 2-flop synchroniser plus rising-edge detect. pending[i] sets on the 3rd rising clk edge after irq_in[i] first rises.
  - A level held high does not re-trigger.
  - Set has priority over a simultaneous clear, except the clear done by take itself.
- Request selection: the highest unmasked pending index p is a request only if IE=1 and p+1 > level.
- FSM states:
  - RUN: if a request exists and eret=0 → ARB. eret takes precedence over a new request in the same cycle; arbitration is re-evaluated next cycle against the restored level.
  - ARB: 1 cycle. Latches sel=p; the choice is locked. Always → TAKE.
  - TAKE: take=1, vector = VEC_BASE + sel*VEC_STRIDE. At the closing edge:
    - push {pc_next, level}; depth++;
    - level ← sel+1;
    - pending[sel] ← 0.
    Always → RUN. A higher request arriving during ARB/TAKE is served later via normal preemption.
- eret in RUN with depth>0: at the edge, pop; level ← saved level; depth--.
  - epc_out shows the pre-pop top during the eret cycle and the new top (0 if empty) afterwards.
  - eret with depth=0 is ignored and sets sticky ERR.
  - eret during ARB or TAKE is ignored and sets ERR.
- Stack: depth N_IRQ, entries {epc[31:0], prev_level[1:0]}. Levels strictly increase on push, so overflow is impossible; a push at full depth is an assertion failure.
- CP0 map:
  - addr 0, EPC: reads top; writes replace the top entry if depth>0.
  - addr 12, STATUS: bit0 IE, bits[8+N_IRQ-1:8] mask, bits[17:16] level (read-only), bit31 ERR (write 1 to clear).
  - addr 13, PENDING: read; write 1 to clear.
  - Other addresses read 0. Writes take effect at the edge and do not cancel a locked selection in TAKE.
- Async rst mid-sequence returns to RUN immediately, dropping take and clearing the stack.

Decomposition:
- Shared package irq_ctrl_pkg: CP0 address constants (CP0_EPC=0, CP0_STATUS=12, CP0_PENDING=13), STATUS bit positions, FSM state encoding (RUN, ARB, TAKE), LEVEL_W=2.
- Sub-module irq_edge_sync: 2-flop synchroniser plus edge detector, one instance per source.

Test Plan:
- Reset, then a single source: irq_in=3'b001 → pending=001 after 3 edges; take asserted 2 cycles later with vector=0x0C00. EPC = pc_next from the TAKE cycle; level=1; pending=0.
- Nested preemption: in level 1, raise irq2 → take with vector=0x0C80, level=3, depth=2. eret → level=1, epc_out = first EPC. eret → level=0.
- Same-cycle requests 3'b011 → only irq1 (0x0C40) taken. After its eret, irq0 (0x0C00) is taken automatically.
- Lower-or-equal priority blocked: in level 2, raise irq0 → no take while level 2; taken after eret.
- Masking and IE: mtc0 STATUS with mask=3'b101, then irq1 → pending=010 but no take. Unmask → taken. IE=0 blocks all sources.
- Error and reset: eret at depth 0 → STATUS bit31=1 and no state change. Assert rst during TAKE → take=0 immediately; level=0, depth=0, pending=0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and types for the irq priority controller
// Holds the CP0 register addresses, the STATUS field positions, the FSM state
// encoding and the width of the in-service level.
package irq_ctrl_pkg;

    localparam int LEVEL_W = 2;

    localparam logic [4:0] CP0_EPC     = 5'd0;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_PENDING = 5'd13;

    localparam int STATUS_IE_BIT    = 0;
    localparam int STATUS_MASK_LSB  = 8;
    localparam int STATUS_LEVEL_LSB = 16;
    localparam int STATUS_ERR_BIT   = 31;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ARB  = 2'd1,
        ST_TAKE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_edge_sync.sv
// rtl/irq_edge_sync.sv - 2-flop synchroniser with rising-edge detect for one irq line
// Ports: clk, rst (async, active-high), irq_async (raw request), rise (one-cycle
// pulse on a synchronised low-to-high transition).
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= irq_async;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    // A held-high line produces a single pulse only.
    assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/irq_priority_ctrl.sv
// rtl/irq_priority_ctrl.sv - nested fixed-priority interrupt controller with EPC/level stack
// Ports: clk, rst (async, active-high); irq_in (raw requests); pc_next (EPC to save);
// eret; cp0_we/cp0_addr/cp0_wdata/cp0_rdata (mtc0/mfc0 port); take/vector (PC
// redirect pulse); epc_out (stack top); level (in-service level); pending (latched).
module irq_priority_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_IRQ      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0C00,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IRQ-1:0]   irq_in,
    input  logic [31:0]        pc_next,
    input  logic               eret,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               take,
    output logic [31:0]        vector,
    output logic [31:0]        epc_out,
    output logic [LEVEL_W-1:0] level,
    output logic [N_IRQ-1:0]   pending
);

    localparam int SEL_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int DEPTH_W = $clog2(N_IRQ + 1);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   top_idx;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   mask;
    logic [N_IRQ-1:0]   masked;
    logic [N_IRQ-1:0]   pend_wclr;
    logic [N_IRQ-1:0]   take_clr;
    logic               ie;
    logic               err;
    logic               req;
    logic               do_pop;
    logic               bad_eret;
    logic               status_we;
    logic [DEPTH_W-1:0] depth;
    logic [31:0]        epc_stk [N_IRQ];
    logic [LEVEL_W-1:0] lvl_stk [N_IRQ];

    for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
        irq_edge_sync u_sync (
            .clk       (clk),
            .rst       (rst),
            .irq_async (irq_in[i]),
            .rise      (rise[i])
        );
    end

    // Highest unmasked pending source; it is a request only if it outranks
    // the in-service level (index p has level p+1, so p+1 > level <=> p >= level).
    always_comb begin
        masked  = pending & mask;
        top_idx = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (masked[i]) top_idx = SEL_W'(i);
        end
        req = ie && (|masked) && (LEVEL_W'(top_idx) >= level);
    end

    always_comb begin
        state_nxt = state;
        do_pop    = 1'b0;
        bad_eret  = 1'b0;
        case (state)
            ST_RUN: begin
                // eret wins; a pending request is re-arbitrated next cycle
                // against the restored level.
                if (eret) begin
                    if (depth != '0) do_pop = 1'b1;
                    else             bad_eret = 1'b1;
                end else if (req) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                bad_eret  = eret;
                state_nxt = ST_TAKE;
            end
            ST_TAKE: begin
                bad_eret  = eret;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign take      = (state == ST_TAKE);
    assign vector    = take ? (VEC_BASE + 32'(sel) * VEC_STRIDE) : 32'h0;
    assign epc_out   = (depth != '0) ? epc_stk[depth - 1'b1] : 32'h0;
    assign status_we = cp0_we && (cp0_addr == CP0_STATUS);
    assign pend_wclr = (cp0_we && (cp0_addr == CP0_PENDING)) ? cp0_wdata[N_IRQ-1:0] : '0;
    assign take_clr  = take ? (N_IRQ'(1) << sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            sel     <= '0;
            level   <= '0;
            depth   <= '0;
            pending <= '0;
            ie      <= 1'b1;
            mask    <= '1;
            err     <= 1'b0;
            for (int i = 0; i < N_IRQ; i++) begin
                epc_stk[i] <= 32'h0;
                lvl_stk[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == ST_ARB) sel <= top_idx;

            // New edges beat a software clear, but the served source is
            // always retired by take.
            pending <= ((pending & ~pend_wclr) | rise) & ~take_clr;

            if (status_we) begin
                ie   <= cp0_wdata[STATUS_IE_BIT];
                mask <= cp0_wdata[STATUS_MASK_LSB +: N_IRQ];
            end
            err <= (err & ~(status_we & cp0_wdata[STATUS_ERR_BIT])) | bad_eret;

            if (cp0_we && (cp0_addr == CP0_EPC) && (depth != '0))
                epc_stk[depth - 1'b1] <= cp0_wdata;

            if (take) begin
                epc_stk[depth] <= pc_next;
                lvl_stk[depth] <= level;
                depth          <= depth + 1'b1;
                level          <= LEVEL_W'(sel) + LEVEL_W'(1);
            end else if (do_pop) begin
                level <= lvl_stk[depth - 1'b1];
                depth <= depth - 1'b1;
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            CP0_EPC:     cp0_rdata = epc_out;
            CP0_STATUS: begin
                cp0_rdata[STATUS_IE_BIT]                  = ie;
                cp0_rdata[STATUS_MASK_LSB +: N_IRQ]       = mask;
                cp0_rdata[STATUS_LEVEL_LSB +: LEVEL_W]    = level;
                cp0_rdata[STATUS_ERR_BIT]                 = err;
            end
            CP0_PENDING: cp0_rdata = 32'(pending);
            default:     cp0_rdata = 32'h0;
        endcase
    end

    // Levels strictly increase on every push, so a full stack cannot be pushed.
    assert property (@(posedge clk) disable iff (rst) take |-> (depth < DEPTH_W'(N_IRQ)));

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb/tb_irq_priority_ctrl.sv - scoreboard bench for irq_priority_ctrl
module tb_irq_priority_ctrl;

    localparam logic [4:0] A_EPC     = 5'd0;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_PENDING = 5'd13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  irq_in = '0;
    logic [31:0] pc_next = 32'h0000_0100;
    logic        eret = 1'b0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata;
    logic        take;
    logic [31:0] vector;
    logic [31:0] epc_out;
    logic [1:0]  level;
    logic [2:0]  pending;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_takes = 0;
    logic [31:0] last_pc = '0;
    logic [31:0] epc1;
    logic [31:0] epc2;
    logic [31:0] exp_q [$];

    irq_priority_ctrl #(
        .N_IRQ      (3),
        .VEC_BASE   (32'h0000_0C00),
        .VEC_STRIDE (32'h0000_0040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .pc_next   (pc_next),
        .eret      (eret),
        .cp0_we    (cp0_we),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .take      (take),
        .vector    (vector),
        .epc_out   (epc_out),
        .level     (level),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every take pulse must match the oldest expected vector.
    always @(negedge clk) begin
        if (take) begin
            n_takes++;
            last_pc = pc_next;
            if (exp_q.size() == 0) check("take_unexp", vector, 32'h0);
            else                   check("take_vec", vector, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pc_next = pc_next + 32'd4;
    endtask

    task automatic wait_takes(input int target);
        int budget;
        budget = 40;
        while (n_takes < target && budget > 0) begin
            tick();
            budget--;
        end
        if (n_takes < target) check("take_timeout", n_takes, target);
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
        tick();
        cp0_we    = 1'b0;
    endtask

    task automatic mfc0_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_take", 32'(take), 0);
        check("rst_vector", vector, 0);
        check("rst_level", 32'(level), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_epc", epc_out, 0);
        mfc0_check("rst_status", A_STATUS, 32'h0000_0701);
        mfc0_check("rst_other", 5'd5, 32'h0);

        // single source: latency and state after take
        irq_in = 3'b001;
        exp_q.push_back(32'h0000_0C00);
        tick();
        tick();
        check("pend_early", 32'(pending), 0);
        tick();
        check("pend_set", 32'(pending), 32'h1);
        check("take_early", 32'(take), 0);
        tick();
        check("take_arb", 32'(take), 0);
        tick();
        check("take_lat", 32'(take), 1);
        check("vec_single", vector, 32'h0000_0C00);
        wait_takes(1);
        check("single_level", 32'(level), 1);
        check("single_pend", 32'(pending), 0);
        check("single_epc", epc_out, last_pc);
        mfc0_check("single_cp0_epc", A_EPC, last_pc);
        epc1 = last_pc;
        irq_in = 3'b000;

        // nested preemption
        irq_in = 3'b100;
        exp_q.push_back(32'h0000_0C80);
        wait_takes(2);
        check("nest_level", 32'(level), 3);
        check("nest_epc", epc_out, last_pc);
        mfc0_check("nest_status", A_STATUS, 32'h0003_0701);
        epc2 = last_pc;
        eret = 1'b1;
        #1;
        check("eret_pre_top", epc_out, epc2);
        tick();
        eret = 1'b0;
        check("eret1_level", 32'(level), 1);
        check("eret1_epc", epc_out, epc1);
        do_eret();
        check("eret2_level", 32'(level), 0);
        check("eret2_epc", epc_out, 0);
        irq_in = 3'b000;
        repeat (3) tick();

        // simultaneous requests: higher first, lower after its eret
        irq_in = 3'b011;
        exp_q.push_back(32'h0000_0C40);
        exp_q.push_back(32'h0000_0C00);
        wait_takes(3);
        check("same_level_hi", 32'(level), 2);
        check("same_pend_lo", 32'(pending), 32'h1);
        do_eret();
        wait_takes(4);
        check("same_level_lo", 32'(level), 1);
        do_eret();
        check("same_level_end", 32'(level), 0);
        irq_in = 3'b000;
        repeat (3) tick();

        // lower priority blocked while a higher level is in service
        irq_in = 3'b010;
        exp_q.push_back(32'h0000_0C40);
        wait_takes(5);
        irq_in = 3'b011;
        repeat (10) tick();
        check("block_pend", 32'(pending), 32'h1);
        check("block_level", 32'(level), 2);
        check("block_takes", n_takes, 5);
        exp_q.push_back(32'h0000_0C00);
        do_eret();
        wait_takes(6);
        check("block_after", 32'(level), 1);
        do_eret();
        irq_in = 3'b000;
        repeat (3) tick();

        // mask and IE
        mtc0(A_STATUS, 32'h0000_0501);
        mfc0_check("mask_rd", A_STATUS, 32'h0000_0501);
        irq_in = 3'b010;
        repeat (8) tick();
        check("mask_pend", 32'(pending), 32'h2);
        check("mask_takes", n_takes, 6);
        exp_q.push_back(32'h0000_0C40);
        mtc0(A_STATUS, 32'h0000_0701);
        wait_takes(7);
        check("unmask_level", 32'(level), 2);
        do_eret();
        irq_in = 3'b000;
        mtc0(A_STATUS, 32'h0000_0700);
        irq_in = 3'b001;
        repeat (8) tick();
        check("ie_pend", 32'(pending), 32'h1);
        check("ie_takes", n_takes, 7);
        mfc0_check("ie_pend_rd", A_PENDING, 32'h1);
        exp_q.push_back(32'h0000_0C00);
        mtc0(A_STATUS, 32'h0000_0701);
        wait_takes(8);
        check("ie_level", 32'(level), 1);
        do_eret();
        irq_in = 3'b000;
        repeat (3) tick();

        // eret with empty stack
        do_eret();
        check("err_level", 32'(level), 0);
        mfc0_check("err_set", A_STATUS, 32'h8000_0701);
        mtc0(A_STATUS, 32'h8000_0701);
        mfc0_check("err_clr", A_STATUS, 32'h0000_0701);

        // async reset in the middle of a take
        irq_in = 3'b001;
        exp_q.push_back(32'h0000_0C00);
        wait_takes(9);
        check("pre_rst_level", 32'(level), 1);
        irq_in = 3'b101;
        begin
            int budget;
            budget = 20;
            while (!take && budget > 0) begin
                tick();
                budget--;
            end
            check("rst_take_seen", 32'(take), 1);
        end
        rst = 1'b1;
        #1;
        check("rst_mid_take", 32'(take), 0);
        check("rst_mid_level", 32'(level), 0);
        check("rst_mid_pend", 32'(pending), 0);
        check("rst_mid_epc", epc_out, 0);
        irq_in = 3'b000;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        do_eret();
        mfc0_check("rst_depth0", A_STATUS, 32'h8000_0701);
        repeat (4) tick();

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
